// File: rtl/cdc_hs_tx.sv
// Source-domain end of a four-phase req/ack CDC handshake with a 2-flop ack synchronizer.
// Optional ack-timeout monitor enabled by defining CDC_HS_TX_TIMEOUT_EN.
`timescale 1ns/1ps

module cdc_hs_tx #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  in_clk,
  input  logic                  in_rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  hs_req,
  output logic [DATA_WIDTH-1:0] hs_data,
  input  logic                  hs_ack,
  output logic                  tx_done,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  (* async_reg = "true" *) logic ack_meta_q;
  logic ack_s_q;

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= hs_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        req_d = 1'b1;
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        req_d = 1'b0;
        if (!ack_s_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // Ready is decoded from the next state so it rises together with tx_done.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign hs_req   = req_q;
  assign hs_data  = data_q;
  assign tx_done  = done_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             busy, entering, hit;

  assign busy     = (state_q == ST_REQ) || (state_q == ST_REL);
  assign entering = (state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_REL));

  always_comb begin
    cnt_d = cnt_q;
    hit   = 1'b0;
    if (entering) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
      hit   = (cnt_d == CNT_MAX);
    end
    // Set has priority over a simultaneous clear.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (hit)     err_d = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-domain end of the four-phase req/ack clock-domain-crossing handshake. Accepts a word over a valid/ready interface, drives a stable data bus plus a level `hs_req` toward the destination domain, and waits for the destination's `hs_ack` before accepting the next word. The destination samples `hs_req` through a `cdc_2ff` and returns `hs_ack`. This block synchronizes `hs_ack` internally.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the transferred word.
- `TIMEOUT_CYCLES`, 1024: ack timeout in `in_clk` cycles. Used only with `CDC_HS_TX_TIMEOUT_EN`. Legal range ≥ 4.

Ports:
- `in_clk`  input  1: source-domain clock.
- `in_rstn`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: upstream word valid.
- `in_ready`  output  1: block can accept a word.
- `in_data`  input  DATA_WIDTH: upstream word.
- `hs_req`  output  1: request level to destination. Driven directly from a flop, glitch-free.
- `hs_data`  output  DATA_WIDTH: held word. Driven directly from flops.
- `hs_ack`  input  1: acknowledge from destination. Asynchronous to `in_clk`.
- `tx_done`  output  1: one-cycle pulse when a handshake completes.
- `timeout_err`  output  1: sticky ack-timeout flag.
- `err_clr`  input  1: clears `timeout_err`.

## Operation
- `hs_ack` passes through two flops with async reset to 0 before use. The first flop carries `async_reg = "true"`. The second flop's output is `ack_s`.
- State machine, 2-bit encoding:
  - **IDLE**:
    - `in_ready`=1.
    - On `in_valid && in_ready`: `hs_data` <= `in_data`, `hs_req` <= 1, go to REQ.
  - **REQ**:
    - `in_ready`=0, `hs_req`=1.
    - `hs_data` is frozen.
    - When `ack_s`=1: `hs_req` <= 0, go to REL.
  - **REL**:
    - `in_ready`=0, `hs_req`=0.
    - `hs_data` is still frozen.
    - When `ack_s`=0: `tx_done` <= 1 for one cycle, go to IDLE.
- `hs_data` changes only on the accept edge. It is never modified while in REQ or REL.
- `in_ready` is a registered decode of state. It has no combinational path from `in_valid` or `hs_ack`.
- `in_valid` held high while busy is ignored. The word is taken on the first IDLE cycle, at the same edge that drives `tx_done`'s deassertion.
- `ack_s` already 1 when entering REQ means stale ack: the transition to REL is taken on the first REQ cycle. The destination must not leave ack high between transfers.
- `ack_s` glitches shorter than one `in_clk` are not guaranteed to be seen. Handshake correctness relies only on levels.
- Reset is asynchronous and takes effect immediately:
  - Outputs: `hs_req`=0, `hs_data`=0, `in_ready`=0 during reset, `tx_done`=0, `timeout_err`=0.
  - Internal: state=IDLE, both ack sync flops=0.
  - `in_ready` rises on the first clock edge after reset release.
- Reset mid-handshake drops `hs_req` immediately and abandons the word. The destination side is reset separately by the system.

## Timing
- Accept edge N: `hs_req`=1 and new `hs_data` are visible after edge N.
- Data and req change on the same edge. The destination samples data only after its 2-stage req sync, which gives ≥2 `out_clk` of data settling.
- `hs_ack` rising is seen as `ack_s` 2–3 edges later. `hs_req` falls on the following edge.
- `hs_ack` falling takes the same path: `tx_done` pulses after `ack_s`=0 and IDLE is entered on the same edge.
- Minimum source-side cycle count per transfer, excluding destination latency: 6 `in_clk`.
- `tx_done` and `in_ready` rise together.

## Configuration
- Macro `CDC_HS_TX_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to REQ and to REL and increments each cycle spent in those states.
  - Reaching `TIMEOUT_CYCLES` sets `timeout_err`, and the counter saturates. The FSM is unaffected.
  - `err_clr`=1 clears `timeout_err` on the next edge. A simultaneous set wins.
- Not defined: no counter, `timeout_err` tied 0, `err_clr` ignored.

## Test plan
- Single transfer: `in_data`=0xA5A5_0001 with `in_valid` for one cycle. Destination model acks 5 cycles after seeing req.
  - `hs_data`=0xA5A5_0001 stable from accept to `tx_done`.
  - `hs_req` 1→0 only after ack.
  - Exactly one `tx_done` pulse.
- Back-to-back: `in_valid` held high with words 1, 2, 3.
  - Each word is accepted only when `in_ready`=1.
  - `hs_data` never changes while `hs_req`=1 or `ack_s`=1.
  - Three `tx_done` pulses, in order.
- Ack latency sweep: ack delay 0, 1, 7 and 40 cycles, with random `hs_ack` phase relative to `in_clk`.
  - Handshake completes each time.
  - `hs_req` has no pulses shorter than one cycle.
- Reset mid-REQ: assert `in_rstn`=0 between clock edges while `hs_req`=1.
  - `hs_req`=0 and `hs_data`=0 immediately.
  - After release, `in_ready`=1 on the first edge and a new transfer works.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): never ack.
  - `timeout_err`=1 after 16 cycles in REQ.
  - `err_clr` pulse clears it, and it stays 0 after a subsequent ack.
  - With the macro undefined, `timeout_err` stays 0 throughout.
- Stale ack: hold `hs_ack`=1 before accepting a word.
  - REQ→REL on the first REQ cycle.
  - REL→IDLE with a `tx_done` pulse only after `hs_ack` falls.
